// File: rtl/gb_bus_pkg.sv
// Shared encodings for the GameBuddy bus cycle sequencer: op types, FSM states,
// address-bus sources and the output decode used by the sequencer.
package gb_bus_pkg;

    localparam logic [1:0] OP_INT   = 2'b00;
    localparam logic [1:0] OP_FETCH = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b11;

    localparam logic [2:0] SEL_PC = 3'b000;
    localparam logic [2:0] SEL_BC = 3'b100;
    localparam logic [2:0] SEL_DE = 3'b101;
    localparam logic [2:0] SEL_HL = 3'b110;
    localparam logic [2:0] SEL_SP = 3'b111;

    localparam logic [1:0] TS_T1 = 2'b00;
    localparam logic [1:0] TS_T2 = 2'b01;
    localparam logic [1:0] TS_T3 = 2'b10;
    localparam logic [1:0] TS_T4 = 2'b11;

    localparam logic [2:0] M_COUNT_MAX = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] addr_sel;
        logic [2:0] wr_sel;
        logic       last;
    } op_t;

    typedef struct packed {
        logic [1:0] t_cycle;
        logic       m1t1;
        logic       writeback;
        logic       drive_addr;
        logic [2:0] mem_addr_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       rf_wr_en;
        logic [2:0] wr_sel;
        logic       pc_wr_en;
        logic       halted;
    } bus_out_t;

    // Bus controls for a given T-state and the op that state belongs to.
    function automatic bus_out_t decode_outputs(input state_t s, input op_t o);
        bus_out_t r;
        logic     is_mem;
        logic     is_fetch;
        logic     is_read;
        logic     is_write;
        logic [2:0] sel;
        r        = '0;
        is_mem   = (o.kind != OP_INT);
        is_fetch = (o.kind == OP_FETCH);
        is_read  = (o.kind == OP_READ);
        is_write = (o.kind == OP_WRITE);
        sel      = is_fetch ? SEL_PC : o.addr_sel;
        case (s)
            ST_T1: begin
                r.t_cycle      = TS_T1;
                r.drive_addr   = is_mem;
                r.mem_addr_sel = sel;
                r.m1t1         = is_fetch;
            end
            ST_T2, ST_T3: begin
                r.t_cycle      = (s == ST_T2) ? TS_T2 : TS_T3;
                r.drive_addr   = is_mem;
                r.mem_addr_sel = sel;
                r.mem_rd       = is_fetch | is_read;
                r.mem_wr       = is_write;
            end
            ST_T4: begin
                r.t_cycle      = TS_T4;
                r.drive_addr   = is_mem;
                r.mem_addr_sel = sel;
                r.writeback    = 1'b1;
                r.rf_wr_en     = is_read;
                r.wr_sel       = is_read ? o.wr_sel : 3'b000;
                r.pc_wr_en     = is_fetch;
            end
            ST_HALT: begin
                r.halted = 1'b1;
            end
            default: begin
                r = '0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bus_cycle_sequencer.sv
// SM83-style M-cycle sequencer: walks T1..T4 per decoder op and produces the
// memory strobes and register-file write pulses at the right T-state.
module bus_cycle_sequencer
    import gb_bus_pkg::*;
#(
    parameter int OP_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [OP_W-1:0] op_type,
    input  logic [2:0]      op_addr_sel,
    input  logic [2:0]      op_wr_sel,
    input  logic            op_last,
    output logic            op_ready,
    input  logic            mem_wait,
    input  logic            halt,
    output logic [1:0]      t_cycle,
    output logic            m1t1,
    output logic            writeback,
    output logic            drive_addr,
    output logic [2:0]      mem_addr_sel,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            rf_wr_en,
    output logic [2:0]      wr_sel,
    output logic            pc_wr_en,
    output logic [2:0]      m_count,
    output logic            halted
);

    state_t   state;
    state_t   next_state;
    op_t      op;
    op_t      next_op;
    bus_out_t outs;
    logic     accept;

    // An offered op beats a pending halt in T4, so ready stays up for it then.
    always_comb begin
        op_ready = rst && ((state == ST_IDLE) ||
                           (state == ST_T4 && (!halt || op_valid)));
        accept   = op_valid && op_ready;
        next_op  = op;
        if (accept) begin
            next_op = '{op_type, op_addr_sel, op_wr_sel, op_last};
        end
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_T1;
                end else if (halt) begin
                    next_state = ST_HALT;
                end
            end
            ST_T1: next_state = ST_T2;
            ST_T2: begin
                if (!mem_wait) begin
                    next_state = ST_T3;
                end
            end
            ST_T3: next_state = ST_T4;
            ST_T4: begin
                if (accept) begin
                    next_state = ST_T1;
                end else if (halt) begin
                    next_state = ST_HALT;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (!halt) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from the state being entered, so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            op      <= '0;
            m_count <= 3'd0;
            outs    <= '0;
        end else begin
            state <= next_state;
            op    <= next_op;
            outs  <= decode_outputs(next_state, next_op);
            if (state == ST_T4) begin
                if (op.last) begin
                    m_count <= 3'd0;
                end else if (m_count != M_COUNT_MAX) begin
                    m_count <= m_count + 3'd1;
                end
            end
        end
    end

    assign t_cycle      = outs.t_cycle;
    assign m1t1         = outs.m1t1;
    assign writeback    = outs.writeback;
    assign drive_addr   = outs.drive_addr;
    assign mem_addr_sel = outs.mem_addr_sel;
    assign mem_rd       = outs.mem_rd;
    assign mem_wr       = outs.mem_wr;
    assign rf_wr_en     = outs.rf_wr_en;
    assign wr_sel       = outs.wr_sel;
    assign pc_wr_en     = outs.pc_wr_en;
    assign halted       = outs.halted;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Scoreboard bench for bus_cycle_sequencer: issued ops queue their expected
// M-cycle profile, a negedge monitor checks it at each writeback pulse.
module tb_bus_cycle_sequencer;
    import gb_bus_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       op_valid = 1'b0;
    logic [1:0] op_type = 2'b00;
    logic [2:0] op_addr_sel = 3'b000;
    logic [2:0] op_wr_sel = 3'b000;
    logic       op_last = 1'b0;
    logic       op_ready;
    logic       mem_wait;
    logic       halt = 1'b0;
    logic [1:0] t_cycle;
    logic       m1t1;
    logic       writeback;
    logic       drive_addr;
    logic [2:0] mem_addr_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       rf_wr_en;
    logic [2:0] wr_sel;
    logic       pc_wr_en;
    logic [2:0] m_count;
    logic       halted;

    bus_cycle_sequencer #(.OP_W(2)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
        .op_addr_sel(op_addr_sel), .op_wr_sel(op_wr_sel), .op_last(op_last),
        .op_ready(op_ready), .mem_wait(mem_wait), .halt(halt),
        .t_cycle(t_cycle), .m1t1(m1t1), .writeback(writeback),
        .drive_addr(drive_addr), .mem_addr_sel(mem_addr_sel), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .rf_wr_en(rf_wr_en), .wr_sel(wr_sel),
        .pc_wr_en(pc_wr_en), .m_count(m_count), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ty;
        logic [2:0] addr;
        logic [2:0] wr;
        logic [2:0] mc;
        int         waits;
    } exp_t;

    exp_t       exp_q[$];
    int         wait_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    logic [2:0] model_mc = 3'd0;
    logic       stray_wait = 1'b0;

    task automatic check_output(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic logic [2:0] exp_addr(input exp_t e);
        return (e.ty == OP_FETCH) ? SEL_PC : e.addr;
    endfunction

    // Stalls T2 by the op's wait count; outside T2 optionally drives a stray wait.
    initial begin : wait_driver
        int wait_left;
        bit in_t2;
        mem_wait  = 1'b0;
        wait_left = 0;
        in_t2     = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wait_left = 0;
                in_t2     = 0;
                mem_wait  = 1'b0;
            end else if (t_cycle == TS_T2) begin
                if (!in_t2) begin
                    in_t2     = 1;
                    wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                end
                if (wait_left > 0) begin
                    mem_wait = 1'b1;
                    wait_left--;
                end else begin
                    mem_wait = 1'b0;
                end
            end else begin
                in_t2    = 0;
                mem_wait = stray_wait;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        int t2_n, rd_n, wr_n, m1_n, rf_n, pc_n, addr_err;
        t2_n = 0; rd_n = 0; wr_n = 0; m1_n = 0; rf_n = 0; pc_n = 0; addr_err = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                t2_n = 0; rd_n = 0; wr_n = 0; m1_n = 0; rf_n = 0; pc_n = 0; addr_err = 0;
            end else begin
                if (drive_addr) begin
                    if (exp_q.size() == 0) addr_err++;
                    else if (mem_addr_sel != exp_addr(exp_q[0])) addr_err++;
                end
                if (t_cycle == TS_T2) t2_n++;
                if (mem_rd) rd_n++;
                if (mem_wr) wr_n++;
                if (m1t1) m1_n++;
                if (rf_wr_en) rf_n++;
                if (pc_wr_en) pc_n++;
                if (writeback) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_writeback", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("t2_clocks", t2_n, e.waits + 1);
                        check_output("rd_clocks", rd_n,
                            (e.ty == OP_FETCH || e.ty == OP_READ) ? e.waits + 2 : 0);
                        check_output("wr_clocks", wr_n, (e.ty == OP_WRITE) ? e.waits + 2 : 0);
                        check_output("m1t1_count", m1_n, (e.ty == OP_FETCH) ? 1 : 0);
                        check_output("rf_wr_pulses", rf_n, (e.ty == OP_READ) ? 1 : 0);
                        check_output("rf_wr_en_t4", int'(rf_wr_en), (e.ty == OP_READ) ? 1 : 0);
                        check_output("wr_sel_t4", int'(wr_sel),
                            (e.ty == OP_READ) ? int'(e.wr) : 0);
                        check_output("pc_wr_pulses", pc_n, (e.ty == OP_FETCH) ? 1 : 0);
                        check_output("m_count_t4", int'(m_count), int'(e.mc));
                        check_output("addr_sel_errors", addr_err, 0);
                        check_output("drive_addr_t4", int'(drive_addr), (e.ty != OP_INT) ? 1 : 0);
                        check_output("strobes_t4", int'({mem_rd, mem_wr}), 0);
                    end
                    t2_n = 0; rd_n = 0; wr_n = 0; m1_n = 0; rf_n = 0; pc_n = 0; addr_err = 0;
                end
            end
        end
    end

    // Offers one op, waits for acceptance, and queues its expected profile.
    task automatic apply_stimulus(input logic [1:0] ty, input logic [2:0] addr,
                                  input logic [2:0] wr, input logic last, input int waits);
        bit accepted;
        accepted    = 0;
        op_type     = ty;
        op_addr_sel = addr;
        op_wr_sel   = wr;
        op_last     = last;
        op_valid    = 1'b1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (op_ready) begin
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            check_output("accept_timeout", 0, 1);
            op_valid = 1'b0;
            return;
        end
        wait_q.push_back(waits);
        @(posedge clk);
        exp_q.push_back('{ty, addr, wr, model_mc, waits});
        model_mc = last ? 3'd0 : ((model_mc == 3'd7) ? 3'd7 : model_mc + 3'd1);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check_output("drain_queue_empty", exp_q.size(), 0);
    endtask

    function automatic int all_outputs();
        return int'({t_cycle, m1t1, writeback, drive_addr, mem_addr_sel, mem_rd, mem_wr,
                     rf_wr_en, wr_sel, pc_wr_en, m_count, halted, op_ready});
    endfunction

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_outputs", all_outputs(), 0);
        #1 rst = 1'b1;
        #1;
        check_output("ready_after_reset", int'(op_ready), 1);

        // Instruction ending with op_last: m_count 0,1,2 then back to 0.
        apply_stimulus(OP_FETCH, 3'b000, 3'b000, 1'b0, 0);
        apply_stimulus(OP_READ,  SEL_BC, 3'b001, 1'b0, 0);
        apply_stimulus(OP_READ,  SEL_HL, 3'b010, 1'b1, 0);
        drain();
        @(negedge clk);
        check_output("m_count_cleared", int'(m_count), 0);

        // Three back-to-back fetches with no bubble between M-cycles.
        fork
            begin
                apply_stimulus(OP_FETCH, 3'b000, 3'b000, 1'b0, 0);
                apply_stimulus(OP_FETCH, 3'b000, 3'b000, 1'b0, 0);
                apply_stimulus(OP_FETCH, 3'b000, 3'b000, 1'b0, 0);
            end
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (m1t1) begin
                        seen = 1;
                        break;
                    end
                end
                check_output("b2b_first_t1", int'(seen), 1);
                for (int k = 0; k < 12; k++) begin
                    if (k > 0) @(negedge clk);
                    check_output($sformatf("b2b_clk%0d", k), int'({t_cycle, m1t1, pc_wr_en}),
                        (k % 4) * 4 + ((k % 4 == 0) ? 2 : 0) + ((k % 4 == 3) ? 1 : 0));
                end
            end
        join
        drain();

        // Read (HL) into B with two wait states.
        apply_stimulus(OP_READ, SEL_HL, 3'b000, 1'b1, 2);
        drain();

        // Write via DE with mem_wait toggling outside T2, which must not stall.
        stray_wait = 1'b1;
        apply_stimulus(OP_WRITE, SEL_DE, 3'b101, 1'b0, 0);
        drain();
        stray_wait = 1'b0;

        // Internal ops drive m_count up to saturation, then op_last clears it.
        for (int i = 0; i < 8; i++) apply_stimulus(OP_INT, SEL_SP, 3'b111, 1'b0, 0);
        apply_stimulus(OP_INT, SEL_BC, 3'b011, 1'b1, 0);
        drain();
        @(negedge clk);
        check_output("m_count_after_sat", int'(m_count), 0);

        // Halt raised with ops pending: both ops run, then HALT.
        #2 halt = 1'b1;
        apply_stimulus(OP_READ,  SEL_SP, 3'b011, 1'b0, 0);
        apply_stimulus(OP_WRITE, SEL_HL, 3'b000, 1'b1, 0);
        drain();
        @(negedge clk);
        check_output("halted_set", int'(halted), 1);
        check_output("halt_not_ready", int'(op_ready), 0);
        repeat (2) @(negedge clk);
        check_output("halt_holds", int'({halted, mem_rd, mem_wr, t_cycle}), 16);
        #2 halt = 1'b0;
        @(negedge clk);
        check_output("halt_released", int'({halted, op_ready}), 1);

        // Reset in T3 of a read aborts it; a new op starts T1 one clock after acceptance.
        apply_stimulus(OP_READ, SEL_HL, 3'b100, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (t_cycle == TS_T3) break;
        end
        check_output("reached_t3", int'(t_cycle), int'(TS_T3));
        #2 rst = 1'b0;
        #1;
        check_output("midcycle_reset_outputs", all_outputs(), 0);
        exp_q.delete();
        wait_q.delete();
        model_mc = 3'd0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        apply_stimulus(OP_FETCH, 3'b000, 3'b000, 1'b0, 0);
        check_output("t1_after_reset", int'({t_cycle, m1t1, drive_addr}), 3);
        drain();

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_cycle_sequencer.md
# bus_cycle_sequencer

Sequencer that drives the GameBuddy register file and memory bus through SM83-style machine cycles. Each M-cycle is four T-states (T1–T4). The decoder hands the sequencer one bus operation per M-cycle: instruction fetch, memory read, memory write, or internal. The sequencer then produces the T-state count, address-drive and address-select controls, memory strobes, and the register-file `writeback`/`wr_en`/`pc_wr_en` pulses at the correct T-state. It sits between the instruction decoder and `register_file_new`/memory interface and owns all bus timing.

## Interface
Parameters:
- `OP_W`, 2, width of op_type encoding.

Ports:
- `clk`  in  1  system clock; one clock = one T-state.
- `rst`  in  1  reset, asynchronous, active-low.
- `op_valid`  in  1  decoder presents an operation.
- `op_type`  in  2  operation type: 00 internal, 01 fetch, 10 read, 11 write.
- `op_addr_sel`  in  3  address source for read/write: 100 BC, 101 DE, 110 HL, 111 SP. Ignored for fetch, which always uses PC (000).
- `op_wr_sel`  in  3  register-file destination for read data.
- `op_last`  in  1  this M-cycle ends the instruction.
- `op_ready`  out  1  sequencer accepts an op this clock.
- `mem_wait`  in  1  memory not ready; sampled in T2.
- `halt`  in  1  enter low-power halt.
- `t_cycle`  out  2  current T-state: 00=T1 … 11=T4.
- `m1t1`  out  1  T1 of a fetch M-cycle.
- `writeback`  out  1  register-file write strobe.
- `drive_addr`  out  1  register file drives the address bus.
- `mem_addr_sel`  out  3  address source select.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `rf_wr_en`  out  1  register write enable.
- `wr_sel`  out  3  register write select.
- `pc_wr_en`  out  1  PC update enable.
- `m_count`  out  3  M-cycle index within the current instruction.
- `halted`  out  1  sequencer is in HALT.

## Operation
- FSM states: IDLE, T1, T2, T3, T4, HALT. All outputs are registered or decoded from registered state plus the latched op.
- Reset (rst=0): state=IDLE. Every output is 0, including `t_cycle=00` and `m_count=0`. The op latch is cleared to internal/000/000. Reset mid-cycle aborts the M-cycle with no strobe completing.
- `op_ready` = 1 in IDLE, and in T4 when `halt`=0; 0 elsewhere. On `op_valid & op_ready` the op fields are latched and the next state is T1.
- IDLE: holds while `op_valid`=0. If `halt`=1 and no op is accepted, go to HALT.
- T1: `t_cycle=00`. `drive_addr`=1 unless the op is internal. `mem_addr_sel`=000 for fetch, else the latched `op_addr_sel`. `m1t1`=1 for fetch.
- T2: `t_cycle=01`. `mem_rd`=1 for fetch/read; `mem_wr`=1 for write. If `mem_wait`=1, stay in T2, holding all outputs.
- T3: `t_cycle=10`. Strobes and address held as in T2.
- T4: `t_cycle=11`. Strobes are low and `drive_addr` stays high.
  - `writeback`=1 for one clock.
  - For read: `rf_wr_en`=1 and `wr_sel`=latched `op_wr_sel`.
  - For fetch: `pc_wr_en`=1.
  - For internal/write: `rf_wr_en`=0 and `wr_sel`=000.
- Leaving T4, three cases:
  - If an op is accepted, go to T1.
  - Else if `halt`=1, go to HALT.
  - Else go to IDLE.
- `m_count` increments at T4 exit and saturates at 7. It returns to 0 at T4 exit when the latched `op_last`=1.
- Internal ops run all four T-states with `drive_addr`, `mem_rd`, `mem_wr` and `rf_wr_en` at 0. `writeback` still pulses.
- HALT: `halted`=1 and all strobes 0. Leave to IDLE on the first clock with `halt`=0.

## Timing
- Op accepted in IDLE at edge n gives T1 at edge n+1. M-cycle length is 4 clocks plus the number of T2 clocks with `mem_wait`=1.
- An op accepted in T4 gives T1 on the next clock, so back-to-back M-cycles have zero bubbles.
- `mem_wait` is ignored outside T2. `op_valid` changes outside `op_ready` have no effect.
- When `halt` and `op_valid` are both high in IDLE or T4, the op wins and halt is re-evaluated at the next T4.
- `writeback`, `rf_wr_en` and `pc_wr_en` are each exactly one clock wide per M-cycle, never during wait stalls.

## Structure
- Package `gb_bus_pkg` holds:
  - op_type constants: OP_INT, OP_FETCH, OP_READ, OP_WRITE.
  - FSM state encoding.
  - address-select constants: SEL_PC=000, SEL_BC=100, SEL_DE=101, SEL_HL=110, SEL_SP=111.
- Single module, no sub-module. The op latch, T-state FSM and `m_count` are small enough to live together.

## Test plan
- **Reset mid-T3 of a read:** assert rst=0 → all outputs 0 and state IDLE. A new op after release → T1 on the next clock.
- **Back-to-back fetches:** fetch with op_valid held for 3 M-cycles → `t_cycle` 00,01,10,11 repeating with no gap. `m1t1` high at clocks 0, 4 and 8. `pc_wr_en` high at clocks 3, 7 and 11.
- **Read HL to B with wait:** op_type=10, addr_sel=110, wr_sel=000, `mem_wait`=1 for 2 T2 clocks → M-cycle lasts 6 clocks. `mem_rd` high for 4 clocks. `rf_wr_en`=1 with `wr_sel`=000 on clock 5 only.
- **Write via DE:** `mem_addr_sel`=101 from T1 to T4, `mem_wr` high in T2–T3, `rf_wr_en`=0 throughout.
- **op_last sequence:** fetch, read, read with op_last=1 on the third → `m_count` 0→1→2, then 0 after the third T4.
- **Halt:** halt=1 at T4 with op_valid=0 → `halted`=1 and `op_ready`=0. With halt=1 and op_valid=1 together, the op runs first. Dropping halt → IDLE → `op_ready`=1.
